// File: rtl/merlin_mtimer.sv
// merlin_mtimer: RISC-V machine timer on the Merlin data port.
// 64-bit mtime with prescaler, mtimecmp compare, level interrupt.
module merlin_mtimer #(
  parameter logic [15:0] C_PRESCALE = 16'd0
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  output logic        treqready_o,
  input  logic        treqvalid_i,
  input  logic        treqdvalid_i,
  input  logic [31:0] treqaddr_i,
  input  logic [31:0] treqdata_i,
  input  logic        trspready_i,
  output logic        trspvalid_o,
  output logic [31:0] trspdata_o,
  output logic        irq_timer_o
);

  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic [63:0] cmp_q;
  logic [63:0] cmp_d;
  logic [15:0] pre_q;
  logic [15:0] pre_d;
  logic [15:0] pcnt_q;
  logic [15:0] pcnt_d;
  logic        rsp_valid_q;
  logic        rsp_valid_d;
  logic [31:0] rsp_data_q;
  logic [31:0] rsp_data_d;
  logic [31:0] rd_data;
  logic        irq_q;
  logic        accept;
  logic        wr;
  logic        rd;
  logic        tick;
  logic [2:0]  sel;
  logic [7:0]  hit;
  logic        unused_addr;

  assign sel         = treqaddr_i[4:2];
  assign unused_addr = ^{treqaddr_i[31:5], treqaddr_i[1:0]};

  assign treqready_o = ~rsp_valid_q | trspready_i;
  assign accept      = treqvalid_i & treqready_o;
  assign wr          = accept & treqdvalid_i;
  assign rd          = accept & ~treqdvalid_i;
  assign tick        = (pcnt_q == pre_q);
  assign hit         = wr ? (8'd1 << sel) : 8'd0;

  always_comb begin
    rd_data = 32'd0;
    unique case (sel)
      3'd0:    rd_data = mtime_q[31:0];
      3'd1:    rd_data = mtime_q[63:32];
      3'd2:    rd_data = cmp_q[31:0];
      3'd3:    rd_data = cmp_q[63:32];
      3'd4:    rd_data = {16'd0, pre_q};
      default: rd_data = 32'd0;
    endcase
  end

  // A write to an mtime half overrides the tick; the other half
  // keeps its pre-tick value, so no carry crosses halves.
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    pcnt_d  = tick ? 16'd0 : pcnt_q + 16'd1;
    cmp_d   = cmp_q;
    pre_d   = pre_q;
    unique case (1'b1)
      hit[0]: mtime_d = {mtime_q[63:32], treqdata_i};
      hit[1]: mtime_d = {treqdata_i, mtime_q[31:0]};
      hit[2]: cmp_d[31:0] = treqdata_i;
      hit[3]: cmp_d[63:32] = treqdata_i;
      hit[4]: begin
        pre_d  = treqdata_i[15:0];
        pcnt_d = 16'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_data;
    end else if (trspready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      mtime_q <= 64'd0;
      cmp_q   <= {64{1'b1}};
      pre_q   <= C_PRESCALE;
      pcnt_q  <= 16'd0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Compare of the registered values: one cycle behind the edge
  // that changes mtime or mtimecmp.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (mtime_q >= cmp_q);
    end
  end

  assign trspvalid_o = rsp_valid_q;
  assign trspdata_o  = rsp_data_q;
  assign irq_timer_o = irq_q;

endmodule

// File: doc/merlin_mtimer.md
# merlin_mtimer

Memory-mapped RISC-V machine timer that sits on the Merlin core data port, alongside the SSRAM, behind an external address decoder. It provides a 64-bit free-running `mtime` counter with a programmable prescaler and a 64-bit `mtimecmp` compare register. It drives the core's `irqm_timer_i` input, which the system bench ties to `1'b0` today. Its slave handshake is identical to the SSRAM data-port target, so it drops into the existing `treq*`/`trsp*` wiring.

## Interface

**Parameters**
- `C_PRESCALE`, default `16'd0`: reset value of the PRESCALE register. `mtime` ticks once every PRESCALE+1 cycles.

**Ports**
- `clk_i` input 1: sole clock. All state updates on its rising edge.
- `resetn_i` input 1: reset, asynchronous and active-low.
- `treqready_o` output 1: request can be accepted this cycle.
- `treqvalid_i` input 1: request valid. Already qualified by the external address decode.
- `treqdvalid_i` input 1: request is a write when 1, a read when 0.
- `treqaddr_i` input 32: byte address. Only `[4:2]` is decoded.
- `treqdata_i` input 32: write data. Always a full 32-bit word.
- `trspready_i` input 1: master can take a response.
- `trspvalid_o` output 1: read response valid.
- `trspdata_o` output 32: read response data.
- `irq_timer_o` output 1: level timer interrupt, `mtime >= mtimecmp`.

## Operation

**Register map**, selected by `treqaddr_i[4:2]`:
- 0: `MTIME_LO`.
- 1: `MTIME_HI`.
- 2: `MTIMECMP_LO`.
- 3: `MTIMECMP_HI`.
- 4: `PRESCALE`. Bits `[15:0]` are read/write; bits `[31:16]` read 0.
- 5–7: unmapped. Reads return 0; writes are ignored.

**Request handling**
- A request is accepted when `treqvalid_i & treqready_o`.
- `treqready_o = ~trspvalid_o | trspready_i`, combinational.
- A write updates the target register on the accepting edge and generates no response.
- A read loads the response register. `trspdata_o` holds the register value as it was before any update on that same edge.

**Response buffer**
- Single entry.
- `trspvalid_o` sets on an accepted read.
- It clears when `trspready_i` is high and no new read is accepted.
- An accepted read together with `trspready_i` keeps `trspvalid_o` high and loads the new data (back-to-back reads).

**Prescaler and counter**
- A 16-bit prescale counter `pcnt` counts 0..PRESCALE.
- When `pcnt == PRESCALE`, a tick fires and `pcnt` returns to 0. Otherwise `pcnt` increments.
- On a tick, `mtime <= mtime + 1`. The increment is 64-bit, so the carry propagates from LO into HI.
  - All-ones wraps to 0.
- A write to PRESCALE also clears `pcnt`.

**Collisions**
- A write to `MTIME_LO` or `MTIME_HI` on a tick edge: the written half takes the written value.
- The other half takes its pre-tick value. No increment is applied that cycle, and there is no carry.
- Writes to `MTIMECMP_*` never interact with ticks.

**Interrupt**
- `irq_timer_o` is registered from an unsigned 64-bit compare `mtime >= mtimecmp`, using post-update register values.
- It deasserts only via a write that makes the compare false.

## Timing

**Reset values** (asynchronous, while `resetn_i` is low):
- `mtime = 0`.
- `mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF`.
- `PRESCALE = C_PRESCALE`.
- `pcnt = 0`.
- `trspvalid_o = 0`.
- `trspdata_o = 0`.
- `irq_timer_o = 0`.
- `treqready_o = 1`.

**Latencies**
- Read: response one cycle after acceptance.
- Write: effective on the accepting edge. A read accepted on the next cycle returns the new value.
- Interrupt: `irq_timer_o` changes one cycle after the register edge that changes the compare result.

**Handshake**
- With `trspready_i` held low, one read is accepted and then `treqready_o` drops.
- Writes are stalled in this state as well.

**Reset mid-operation**
- An outstanding response is discarded and `trspvalid_o` drops immediately.

**Reset deassertion**
- The first tick occurs PRESCALE+1 cycles after `resetn_i` rises.

## Test plan

- **Reset defaults:** after reset, read regs 0–4 with PRESCALE=0 → `MTIMECMP_LO`/`MTIMECMP_HI` = `0xFFFFFFFF`, PRESCALE = 0, `irq_timer_o` = 0. `MTIME_LO` = 0 or small, consistent with cycles elapsed since reset.
- **Prescale:** write PRESCALE=3, then `MTIME_LO`=0, then wait 40 cycles → `MTIME_LO` = 10, and consecutive reads show increments every 4 cycles.
- **Carry and wrap:**
  - Write `MTIME_HI`=0, `MTIME_LO`=`0xFFFFFFFE`, PRESCALE=0 → after 2 ticks, HI=1 and LO=0.
  - With `mtime` = all-ones, the next tick gives `mtime` = 0.
- **Interrupt:**
  - `mtimecmp` = 100 with `mtime` running from 0 → `irq_timer_o` rises one cycle after `mtime` reaches 100 and stays high.
  - Writing `MTIMECMP_HI`=1 → `irq_timer_o` low one cycle later.
- **Backpressure:**
  - Issue 3 back-to-back reads with `trspready_i`=0 → one accepted, `treqready_o`=0, and `trspdata_o` stable.
  - Raise `trspready_i` → remaining reads complete at one per cycle with the correct data order.
- **Collisions and unmapped:**
  - Write `MTIME_LO`=`0x55` exactly on a tick edge → the next read returns `0x55` (or `0x56` if a tick occurred between), never `0x56` on the same edge.
  - Read address `0x1C` → 0.
  - Assert reset with `trspvalid_o`=1 → `trspvalid_o`=0 asynchronously.
